// File: rtl/hack_cpu_seq.sv
// Hack CPU control and register stage. A multi-cycle fetch / load / execute / store
// sequencer that owns A, D and PC and wraps an external combinational Hack ALU.
module hack_cpu_seq #(
  parameter int unsigned PC_RESET = 0,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_done
);

  typedef enum logic [1:0] {S_FETCH, S_LOAD_M, S_EXEC, S_STORE_M} state_t;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);

  state_t            state, state_n;
  logic [15:0]       a_reg, d_reg, mbuf, wdata;
  logic [12:0]       ir;  // a bit, comp, dest and jump fields of the current C-instruction
  logic [ADDR_W-1:0] waddr, pc_inc;
  logic              imem_fire, dmem_fire, jmp, retire;
  logic              unused_bits;

  // Bits 14:13 of a C-instruction carry no meaning.
  assign unused_bits = ^imem_rdata[14:13];

  assign imem_fire = imem_req & imem_ack;
  assign dmem_fire = dmem_req & dmem_ack;
  assign pc_inc    = pc + ADDR_W'(1);
  assign jmp       = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_zr & ~alu_ng);

  assign imem_addr  = pc;
  assign dmem_addr  = (state == S_STORE_M) ? waddr : a_reg[ADDR_W-1:0];
  assign dmem_wdata = wdata;

  assign alu_x  = d_reg;
  assign alu_y  = ir[12] ? mbuf : a_reg;
  assign alu_zx = ir[11];
  assign alu_nx = ir[10];
  assign alu_zy = ir[9];
  assign alu_ny = ir[8];
  assign alu_f  = ir[7];
  assign alu_no = ir[6];

  // NOTE: asynchronous active-low reset; every flop clears the moment reset_n falls,
  // so an in-flight request is dropped without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_n;
  end

  // NOTE: defaults first so every path assigns state_n and retire; no latches.
  always_comb begin
    state_n = state;
    retire  = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_fire) begin
          if (!imem_rdata[15])     retire  = 1'b1;
          else if (imem_rdata[12]) state_n = S_LOAD_M;
          else                     state_n = S_EXEC;
        end
      end
      S_LOAD_M: if (dmem_fire) state_n = S_EXEC;
      S_EXEC: begin
        if (ir[3]) state_n = S_STORE_M;
        else begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_STORE_M: begin
        if (dmem_fire) begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Handshake outputs are registered from the next state: a request rises the cycle
  // its state is entered and falls the cycle after its ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      imem_req   <= (state_n == S_FETCH);
      dmem_req   <= (state_n == S_LOAD_M) || (state_n == S_STORE_M);
      dmem_we    <= (state_n == S_STORE_M);
      instr_done <= retire;
    end
  end

  // NOTE: non-blocking assignments mean the jump target and store address in EXEC
  // see A as it was before this cycle's write-back, which is the required behaviour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      d_reg <= '0;
      pc    <= PC_INIT;
      ir    <= '0;
      mbuf  <= '0;
      wdata <= '0;
      waddr <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_fire) begin
            if (!imem_rdata[15]) begin
              a_reg <= imem_rdata;
              pc    <= pc_inc;
            end else begin
              ir <= imem_rdata[12:0];
            end
          end
        end
        S_LOAD_M: if (dmem_fire) mbuf <= dmem_rdata;
        S_EXEC: begin
          pc <= jmp ? a_reg[ADDR_W-1:0] : pc_inc;
          if (ir[4]) d_reg <= alu_out;
          if (ir[5]) a_reg <= alu_out;
          if (ir[3]) begin
            wdata <= alu_out;
            waddr <= a_reg[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
